// File: rtl/numgen_pkg.sv
// Shared types, class encodings and class masks for the number generator.
package numgen_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_DONE
   } state_t;

   localparam logic [1:0] SEL_PRIME = 2'b00;
   localparam logic [1:0] SEL_DIV3  = 2'b01;
   localparam logic [1:0] SEL_AND   = 2'b10;
   localparam logic [1:0] SEL_OR    = 2'b11;

   localparam logic [15:0] PRIME_MASK = 16'h28AC;
   localparam logic [15:0] DIV3_MASK  = 16'h9249;

   // Bit n set when value n belongs to the class selected by sel.
   function automatic logic [15:0] class_mask(input logic [1:0] sel);
      logic [15:0] m;
      m = PRIME_MASK | DIV3_MASK;
      case (sel)
         SEL_PRIME: m = PRIME_MASK;
         SEL_DIV3:  m = DIV3_MASK;
         SEL_AND:   m = PRIME_MASK & DIV3_MASK;
         SEL_OR:    m = PRIME_MASK | DIV3_MASK;
         default:   m = PRIME_MASK | DIV3_MASK;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/number_gen_if.sv
// Request/response bundle of number_gen; count exists only with NUMGEN_COUNT_EN.
interface number_gen_if;

   logic       start;
   logic [1:0] sel;
   logic [3:0] out_val;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;
   logic       done;
`ifdef NUMGEN_COUNT_EN
   logic [4:0] count;

   modport master (
      output start, sel, out_ready,
      input  out_val, out_valid, out_last, busy, done, count
   );
   modport slave (
      input  start, sel, out_ready,
      output out_val, out_valid, out_last, busy, done, count
   );
`else
   modport master (
      output start, sel, out_ready,
      input  out_val, out_valid, out_last, busy, done
   );
   modport slave (
      input  start, sel, out_ready,
      output out_val, out_valid, out_last, busy, done
   );
`endif

endinterface

// File: rtl/num_class.sv
// Combinational class test: is i_val a member of the class chosen by i_sel.
import numgen_pkg::*;

module num_class (
   input  logic [3:0] i_val,
   input  logic [1:0] i_sel,
   output logic       o_match
);

   logic [15:0] w_mask;

   assign w_mask  = class_mask(i_sel);
   assign o_match = w_mask[i_val];

endmodule

// File: rtl/number_gen.sv
// Scans 0..15 and emits members of the selected class over a valid/ready port.
// Optional NUMGEN_COUNT_EN adds a count of accepted values per scan.
import numgen_pkg::*;

module number_gen (
   input  logic         clk,
   input  logic         reset,
   number_gen_if.slave  bus
);

   state_t      r_state;
   state_t      w_state_nx;
   logic [3:0]  r_cursor;
   logic [3:0]  w_cursor_nx;
   logic [1:0]  r_sel;
   logic [1:0]  w_sel_nx;
   logic        w_match;
   logic        w_last;
   logic        w_accept;
   logic        w_start_ok;
   logic [15:0] w_mask;
   logic [15:0] w_above;

   num_class u_class (
      .i_val   (r_cursor),
      .i_sel   (r_sel),
      .o_match (w_match)
   );

   // Last match when no class member remains strictly above the cursor.
   assign w_mask     = class_mask(r_sel);
   assign w_above    = (w_mask >> r_cursor) >> 1;
   assign w_last     = (w_above == 16'd0);
   assign w_accept   = (r_state == S_EMIT) && bus.out_ready;
   assign w_start_ok = (r_state == S_IDLE) && bus.start;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cursor <= 4'd0;
         r_sel    <= SEL_PRIME;
      end else begin
         r_state  <= w_state_nx;
         r_cursor <= w_cursor_nx;
         r_sel    <= w_sel_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_cursor_nx   = r_cursor;
      w_sel_nx      = r_sel;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_sel_nx    = bus.sel;
               w_cursor_nx = 4'd0;
               w_state_nx  = S_SCAN;
            end
         end
         S_SCAN: begin
            bus.busy = 1'b1;
            if (w_match)
               w_state_nx = S_EMIT;
            else if (r_cursor == 4'd15)
               w_state_nx = S_DONE;
            else
               w_cursor_nx = r_cursor + 4'd1;
         end
         S_EMIT: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            bus.out_last  = w_last;
            if (bus.out_ready) begin
               if (r_cursor == 4'd15 || w_last) begin
                  w_state_nx = S_DONE;
               end else begin
                  w_cursor_nx = r_cursor + 4'd1;
                  w_state_nx  = S_SCAN;
               end
            end
         end
         S_DONE: begin
            bus.done   = 1'b1;
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign bus.out_val = r_cursor;

`ifdef NUMGEN_COUNT_EN
   logic [4:0] r_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_count <= 5'd0;
      else if (w_start_ok)
         r_count <= 5'd0;
      else if (w_accept)
         r_count <= r_count + 5'd1;
   end

   assign bus.count = r_count;
`else
   logic w_unused;
   assign w_unused = w_start_ok ^ w_accept;
`endif

endmodule

// File: tb/tb_number_gen.sv
// Scoreboard bench for number_gen: randomized scans against a set-based model.
module tb_number_gen;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   number_gen_if intf();

   number_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (intf.slave)
   );

   typedef struct {
      logic [3:0] v;
      logic       last;
   } exp_t;

   exp_t q[$];

   int cmp_n = 0;
   int err_n = 0;
   int done_seen = 0;
   int ncyc = 0;
   int t_start = 0;
   int exp_first = 0;
   bit first_pend = 0;
   bit prev_stall = 0;
   logic [3:0] pv;
   logic pl;
   int mode = 0;
   int stall_v = 0;
   int stall_left = 0;

   function automatic void check(string name, int act, int req);
      cmp_n++;
      if (act != req) begin
         err_n++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Class membership from arithmetic definitions, not from masks.
   function automatic bit member(int s, int v);
      bit p;
      bit m;
      p = (v >= 2);
      for (int d = 2; d < v; d++)
         if (v % d == 0) p = 0;
      m = (v % 3 == 0);
      case (s)
         0: return p;
         1: return m;
         2: return p && m;
         default: return p || m;
      endcase
   endfunction

   function automatic void build(int s);
      exp_t e;
      bit found;
      found = 0;
      q.delete();
      for (int v = 0; v < 16; v++) begin
         if (member(s, v)) begin
            if (!found) exp_first = v;
            found = 1;
            e.v = 4'(v);
            e.last = 1'b1;
            for (int u = v + 1; u < 16; u++)
               if (member(s, u)) e.last = 1'b0;
            q.push_back(e);
         end
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      ncyc++;
      if (reset) begin
         prev_stall = 0;
         first_pend = 0;
      end else begin
         if (intf.done) done_seen++;
         if (prev_stall) begin
            check("hold_valid", int'(intf.out_valid), 1);
            check("hold_val", int'(intf.out_val), int'(pv));
            check("hold_last", int'(intf.out_last), int'(pl));
         end
         if (intf.out_valid && first_pend) begin
            check("first_latency", ncyc - t_start, 2 + exp_first);
            first_pend = 0;
         end
         if (intf.out_valid && intf.out_ready) begin
            if (q.size() == 0) begin
               cmp_n++;
               err_n++;
               $display("FAIL unexpected_out: got %0d, want none", intf.out_val);
            end else begin
               e = q.pop_front();
               check("out_val", int'(intf.out_val), int'(e.v));
               check("out_last", int'(intf.out_last), int'(e.last));
            end
         end
         if (intf.start && !intf.busy && !intf.done) begin
            t_start = ncyc;
            first_pend = 1;
         end
         prev_stall = intf.out_valid && !intf.out_ready;
         pv = intf.out_val;
         pl = intf.out_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      intf.start = 1'b0;
      case (mode)
         0: intf.out_ready = 1'b1;
         1: intf.out_ready = ($urandom_range(3) != 0);
         2: begin
            if (intf.out_valid && int'(intf.out_val) == stall_v
                && stall_left > 0) begin
               intf.out_ready = 1'b0;
               stall_left--;
               intf.start = 1'($urandom_range(1));
               intf.sel = 2'($urandom_range(3));
            end else begin
               intf.out_ready = 1'b1;
            end
         end
         default:
            intf.out_ready = !(intf.out_valid
                               && int'(intf.out_val) == stall_v);
      endcase
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_val"}, int'(intf.out_val), 0);
      check({tag, "_valid"}, int'(intf.out_valid), 0);
      check({tag, "_last"}, int'(intf.out_last), 0);
      check({tag, "_busy"}, int'(intf.busy), 0);
      check({tag, "_done"}, int'(intf.done), 0);
`ifdef NUMGEN_COUNT_EN
      check({tag, "_count"}, int'(intf.count), 0);
`endif
   endtask

   task automatic run_scan(int s, int m);
      int d0;
      int n;
      int k;
      build(s);
      n = q.size();
      mode = m;
      d0 = done_seen;
      intf.sel = 2'(s);
      intf.start = 1'b1;
      tick();
      k = 0;
      while (done_seen == d0 && k < 400) begin
         tick();
         k++;
      end
      if (done_seen == d0) begin
         cmp_n++;
         err_n++;
         $display("FAIL done_timeout: got no done, want done (sel=%0d)", s);
      end
      tick();
      tick();
      check("done_pulses", done_seen - d0, 1);
      check("q_drained", q.size(), 0);
      check("idle_busy", int'(intf.busy), 0);
`ifdef NUMGEN_COUNT_EN
      check("count", int'(intf.count), n);
`endif
   endtask

   initial begin
      int k;
      int d0;
      reset = 1'b1;
      intf.start = 1'b0;
      intf.sel = 2'b00;
      intf.out_ready = 1'b1;
      tick();
      tick();
      tick();
      check_reset_outputs("rst");
      reset = 1'b0;
      tick();

      for (int s = 0; s < 4; s++)
         run_scan(s, 0);

      stall_v = 5;
      stall_left = 5;
      run_scan(0, 2);
      check("stall_used", stall_left, 0);

      for (int r = 0; r < 8; r++)
         run_scan(int'($urandom_range(3)), 1);

      // Reset while stalled on value 7 of a prime scan.
      build(0);
      mode = 3;
      stall_v = 7;
      intf.sel = 2'b00;
      intf.start = 1'b1;
      tick();
      k = 0;
      while (!(intf.out_valid && intf.out_val == 4'd7) && k < 100) begin
         tick();
         k++;
      end
      check("reach_7", int'(intf.out_val), 7);
      tick();
      tick();
      d0 = done_seen;
      reset = 1'b1;
      intf.start = 1'b1;
      intf.out_ready = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outputs("midrst");
      q.delete();
      mode = 0;
      tick();
      tick();
      tick();
      check("no_done_after_rst", done_seen - d0, 0);
      run_scan(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule

// File: doc/number_gen.md
NUMBER_GEN -- requirements
Module: number_gen

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset, as listed below.
- clk  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high reset
REQ-002 The block SHALL have the following data and control ports.
- start  input  1  begin a scan; sampled only in IDLE
- sel  input  2  class: 00 prime, 01 multiple-of-3, 10 prime AND mult-3, 11 prime OR mult-3
- out_val  output  4  current emitted value
- out_valid  output  1  out_val is valid
- out_ready  input  1  consumer accepts out_val
- out_last  output  1  out_val is the final match of the scan
- busy  output  1  high in SCAN or EMIT
- done  output  1  one-cycle pulse at end of scan
- count  output  5  number of accepted values in current/last scan (NUMGEN_COUNT_EN only)

Function
REQ-003 The block SHALL enumerate, in ascending order, every value 0..15 in the class selected by sel; it is the generator counterpart of the team's prime/multiple-of-3 classifier.
REQ-004 Class membership SHALL be: prime = {2,3,5,7,11,13}; mult-3 = {0,3,6,9,12,15}; AND = {3}; OR = union of both sets.
REQ-005 The FSM SHALL have four states: IDLE, SCAN, EMIT, DONE.
REQ-006 In IDLE, start=1 SHALL latch sel, clear cursor to 0, and move to SCAN; start=0 SHALL keep IDLE.
REQ-007 In SCAN the block SHALL test one cursor value per cycle. On a match it SHALL go to EMIT with out_val=cursor. On no match at cursor=15 it SHALL go to DONE. Otherwise it SHALL increment cursor.
REQ-008 In EMIT, out_valid SHALL be 1 and out_val and out_last SHALL be held stable until out_ready=1.
REQ-009 On acceptance (out_valid & out_ready), the block SHALL go to DONE if cursor=15 or out_last=1; otherwise it SHALL increment cursor and return to SCAN.
REQ-010 out_last SHALL be 1 in EMIT exactly when no member of the latched class lies in cursor+1..15.
REQ-011 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-012 Latency: with start accepted in cycle T, value c SHALL first be tested in cycle T+1+c. The first match SHALL have out_valid high from cycle T+2+c.
REQ-013 start and sel SHALL be ignored outside IDLE, and latched sel SHALL NOT change mid-scan.
REQ-014 The cursor SHALL NOT wrap: 15 is the terminal value in both SCAN and EMIT.
REQ-015 out_valid SHALL be 0 in every state except EMIT, and busy SHALL be 0 in IDLE and DONE.

Reset
REQ-016 reset SHALL force IDLE, cursor=0, latched sel=00, out_val=0, out_valid=0, out_last=0, busy=0, done=0, and count=0, all on the next rising edge.
REQ-017 reset asserted mid-scan, including during an EMIT stall, SHALL abort the scan with no done pulse. reset SHALL take priority over start and out_ready.

Configuration
REQ-018 Macro NUMGEN_COUNT_EN, when defined, SHALL add the count port: cleared on accepted start, incremented on each acceptance, held through DONE and IDLE.
REQ-019 Without NUMGEN_COUNT_EN, the count port and its register SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-020 A shared package numgen_pkg SHALL hold:
- the state enum
- the sel encoding constants
- PRIME_MASK = 16'h28AC
- DIV3_MASK = 16'h9249
REQ-021 A combinational sub-module num_class SHALL map (4-bit value, sel) to a match bit using the package masks. The out_last lookahead SHALL use the same class mask.

Verification
REQ-022 sel=00, start, out_ready=1 always -> outputs 2,3,5,7,11,13; out_last only with 13; one done pulse; count=6 when enabled.
REQ-023 sel=01, out_ready=1 -> outputs 0,3,6,9,12,15; first out_valid at T+2; done follows acceptance of 15.
REQ-024 sel=10 -> single output 3 with out_last=1. sel=11 -> 0,2,3,5,6,7,9,11,12,13,15 (count=11).
REQ-025 sel=00 with out_ready held low 5 cycles at value 5 -> out_val=5, out_valid=1 stable throughout. Start pulses and sel changes during the stall are ignored.
REQ-026 reset asserted while stalled in EMIT at value 7 -> next cycle all outputs are at reset values and no done pulse occurs. A new start then restarts from 0.
